sensor_arbiter: RTL and testbench
=================================

Name: sensor_arbiter

Overview:
- Shares one downstream consumer (tree classifier input stage) between NUM_CH serial-to-parallel input buffer channels.
- Per word: grants one ready channel round-robin, latches its word, returns a one-cycle data_processed pulse to that channel, then presents the word plus channel ID on a valid/ready interface.
- Sits between the per-sensor input buffers and the classifier.

Parameters:
- NUM_CH, 4, number of input buffer channels; 2..16.
- DATA_WIDTH, 8, width of each channel word.
- CH_W, $clog2(NUM_CH), derived localparam (not overridable); width of the channel ID.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  when 0, no new grant is issued; an in-flight word completes.
- ch_mask  in  NUM_CH  per-channel enable; a masked channel is never granted.
- ch_data_ready  in  NUM_CH  data_ready from each input buffer.
- ch_data  in  NUM_CH*DATA_WIDTH  flattened channel words; channel i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- ch_data_processed  out  NUM_CH  one-hot, one-cycle acknowledge back to the granted buffer.
- out_data  out  DATA_WIDTH  granted word.
- out_ch  out  CH_W  index of the channel that produced out_data.
- out_valid  out  1  out_data and out_ch are valid.
- out_ready  in  1  downstream accepts the word on a cycle where out_valid && out_ready.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; out_data=0, out_ch=0, out_valid=0, ch_data_processed=0, busy=0.
  - last_grant=NUM_CH-1, so channel 0 wins first.
- Request vector: req = ch_data_ready & ch_mask.
- FSM states: IDLE, ACK, SEND. All outputs are registered.
- IDLE:
  - Moves to ACK if enable && |req.
  - Winner g = first set bit of req, searching from last_grant+1 and wrapping modulo NUM_CH.
  - On the transition edge: out_data<=ch_data[g], out_ch<=g, ch_data_processed<=(1<<g).
- ACK:
  - Lasts exactly 1 cycle; ch_data_processed[g]=1 during it, and the buffer clears data_ready on the following edge.
  - Next edge: ch_data_processed<=0, out_valid<=1, state SEND.
- SEND:
  - out_valid is held with out_data/out_ch stable until out_valid && out_ready.
  - On that edge: out_valid<=0, last_grant<=g, state IDLE.
- Timing:
  - Latency: request visible at IDLE edge E0 → out_valid high after E1, i.e. 2 cycles.
  - Minimum 3 cycles per word (IDLE→ACK→SEND→IDLE) with out_ready held high.
- Boundary conditions:
  - ch_data_ready[g] drops during ACK: the word is already latched and is still sent.
  - ch_mask or enable changes after grant: no effect on the in-flight word; applies at the next IDLE decision.
  - A sole requester is re-granted after completing a word, but only if its data_ready is high again. It is low for at least the SEND cycle, so the same word is never sent twice.
  - out_ready high in ACK is ignored; the handshake counts only in SEND.
  - All requesters masked or enable=0: stays IDLE, busy=0.
  - reset_n asserted mid-transaction: the word is dropped and the pulse is cleared immediately (async).
- Width rule: index arithmetic is modulo NUM_CH for non-power-of-two NUM_CH; the wrap is explicit and does not rely on CH_W overflow.

Optional Feature:
- Macro: SENSOR_ARB_PRIO0_EN.
- Defined: channel 0 has fixed top priority. If req[0] is set in IDLE it wins regardless of last_grant, and its grant does not update last_grant. Channels 1..NUM_CH-1 rotate round-robin among themselves.
- Undefined: pure round-robin over all channels, as described above.

Decomposition:
- Shared package/header sensor_arb_pkg:
  - state encodings ST_IDLE=2'd0, ST_ACK=2'd1, ST_SEND=2'd2.
  - DATA_WIDTH default constant, shared with the input buffer.
- One combinational sub-module, rr_pick:
  - inputs: req[NUM_CH], last[CH_W].
  - outputs: gnt_idx[CH_W], any.
  - implements the wrap-around first-set-bit search; reused by future arbiters.

Test Plan:
1. Reset release; ch0 data_ready=1, word 8'hA5, mask=4'hF, out_ready=1 → ch_data_processed=4'b0001 for exactly 1 cycle. Next cycle out_valid=1, out_data=8'hA5, out_ch=0. Back to IDLE after 1 cycle.
2. All four channels ready continuously with words 8'h10..8'h13 → grant order 0,1,2,3,0, one word every 3 cycles; each processed pulse is one-hot and one cycle wide.
3. out_ready=0 for 5 cycles while in SEND → out_valid, out_data, out_ch stable; no further ch_data_processed pulses; word accepted on the first out_ready=1 cycle.
4. mask=4'b1010 with all channels ready → only channels 1 and 3 are granted, alternating. Setting enable=0 during SEND lets that word complete, then no new grant and busy=0.
5. reset_n pulsed low during ACK → outputs zero immediately. After release, channel 0 is granted first again.
6. With SENSOR_ARB_PRIO0_EN defined, channels 0 and 2 always ready → every IDLE decision grants channel 0. Without the macro: grants alternate 0,2,0,2.

Source files
------------

// File: rtl/sensor_arb_pkg.sv
// ============================================================================
// Package : sensor_arb_pkg
// Brief   : Shared state encodings and word width for the sensor arbiter and
//           the per-sensor input buffers.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package sensor_arb_pkg;

    // Shared with the serial-to-parallel input buffers.
    localparam int SENSOR_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_SEND = 2'd2
    } arb_state_t;

endpackage : sensor_arb_pkg

`default_nettype wire

// File: rtl/sensor_arbiter_if.sv
// ============================================================================
// Interface : sensor_arbiter_if
// Brief     : Buffer-side handshake (ready/data/processed) and downstream
//             valid/ready word bus of the sensor arbiter.
// Rev       : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sensor_arbiter_if
    import sensor_arb_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = SENSOR_DATA_WIDTH
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            ch_data_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]            ch_data_processed;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [CH_W-1:0]              out_ch;
    logic                         out_valid;
    logic                         out_ready;

    // The arbiter side.
    modport master (
        input  ch_data_ready,
        input  ch_data,
        input  out_ready,
        output ch_data_processed,
        output out_data,
        output out_ch,
        output out_valid
    );

    // Buffers plus consumer side.
    modport slave (
        output ch_data_ready,
        output ch_data,
        output out_ready,
        input  ch_data_processed,
        input  out_data,
        input  out_ch,
        input  out_valid
    );

endinterface : sensor_arbiter_if

`default_nettype wire

// File: rtl/sensor_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker: first set bit of req searching
//          upward from last+1, wrapping modulo NUM_CH.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  wire logic [NUM_CH-1:0] req,
    input  wire logic [CH_W-1:0]   last,
    output logic      [CH_W-1:0]   gnt_idx,
    output logic                   any
);

    int              w_idx;
    logic [CH_W-1:0] w_sel;

    // Explicit modulo so non-power-of-two channel counts wrap correctly.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        w_idx   = 0;
        w_sel   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = (int'(last) + i) % NUM_CH;
            w_sel = w_idx[CH_W-1:0];
            if (!any && req[w_sel]) begin
                any     = 1'b1;
                gnt_idx = w_sel;
            end
        end
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/sensor_arbiter.sv
// ============================================================================
// Module : sensor_arbiter
// Brief  : Shares one downstream consumer between NUM_CH input buffers:
//          grant, one-cycle processed pulse, then valid/ready word delivery.
// Config : SENSOR_ARB_PRIO0_EN - channel 0 gets fixed top priority and the
//          remaining channels rotate among themselves.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_arbiter
    import sensor_arb_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = SENSOR_DATA_WIDTH
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              enable,
    input  wire logic [NUM_CH-1:0] ch_mask,
    sensor_arbiter_if.master       bus,
    output logic                   busy
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [NUM_CH-1:0] c_ch0_bit  = NUM_CH'(1);
    localparam logic [CH_W-1:0]   c_last_rst = CH_W'(NUM_CH - 1);

    arb_state_t            state_q,     state_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [CH_W-1:0]       out_ch_q,    out_ch_d;
    logic                  out_valid_q, out_valid_d;
    logic [NUM_CH-1:0]     proc_q,      proc_d;
    logic [CH_W-1:0]       last_q,      last_d;
    logic                  busy_q,      busy_d;

    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_req_rr;
    logic [CH_W-1:0]   w_pick_idx;
    logic              w_pick_any;
    logic [CH_W-1:0]   w_win_idx;
    logic              w_win_any;
    logic              w_upd_last;

    assign w_req = bus.ch_data_ready & ch_mask;

`ifdef SENSOR_ARB_PRIO0_EN
    // Channel 0 bypasses the rotation and never moves the rotation pointer.
    assign w_req_rr   = w_req & ~c_ch0_bit;
    assign w_win_any  = w_req[0] | w_pick_any;
    assign w_win_idx  = w_req[0] ? '0 : w_pick_idx;
    assign w_upd_last = (out_ch_q != '0);
`else
    assign w_req_rr   = w_req;
    assign w_win_any  = w_pick_any;
    assign w_win_idx  = w_pick_idx;
    assign w_upd_last = 1'b1;
`endif

    rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_rr_pick (
        .req     (w_req_rr),
        .last    (last_q),
        .gnt_idx (w_pick_idx),
        .any     (w_pick_any)
    );

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        proc_d      = proc_q;
        last_d      = last_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && w_win_any) begin
                    state_d    = ST_ACK;
                    out_data_d = bus.ch_data[w_win_idx*DATA_WIDTH +: DATA_WIDTH];
                    out_ch_d   = w_win_idx;
                    proc_d     = c_ch0_bit << w_win_idx;
                    busy_d     = 1'b1;
                end
            end
            ST_ACK: begin
                state_d     = ST_SEND;
                proc_d      = '0;
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            ST_SEND: begin
                // Word already latched; out_ready only matters from here on.
                if (out_valid_q && bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    if (w_upd_last) begin
                        last_d = out_ch_q;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                proc_d      = '0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            proc_q      <= '0;
            last_q      <= c_last_rst;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            proc_q      <= proc_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ch_data_processed = proc_q;
    assign bus.out_data          = out_data_q;
    assign bus.out_ch            = out_ch_q;
    assign bus.out_valid         = out_valid_q;
    assign busy                  = busy_q;

endmodule : sensor_arbiter

`default_nettype wire

// File: tb/tb_sensor_arbiter.sv
// ============================================================================
// Module : tb_sensor_arbiter
// Brief  : Scoreboard bench for sensor_arbiter with an input-buffer model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sensor_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 8;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable  = 1'b1;
    logic [3:0] ch_mask = 4'hF;
    logic       busy;

    sensor_arbiter_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) bus();

    sensor_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .ch_mask (ch_mask),
        .bus     (bus),
        .busy    (busy)
    );

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   tmo_count = 0;
    bit   idle_chk  = 1'b0;
    bit   chk_gap   = 1'b0;

    logic [3:0] rdy;
    int         cnt[4];
    int         budget[4];
    logic [7:0] word[4];

    initial begin
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus side (single driver of all inputs) ----------
    task automatic drive();
        bus.ch_data_ready = rdy;
        bus.ch_data       = {word[3], word[2], word[1], word[0]};
    endtask

    // Buffer model: clears ready after its pulse, reloads 2 cycles later if budget remains.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            if (bus.ch_data_processed[i]) begin
                rdy[i] = 1'b0;
                cnt[i] = 2;
            end else if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0 && budget[i] > 0) begin
                    budget[i]--;
                    rdy[i] = 1'b1;
                end
            end
        end
        drive();
    endtask

    task automatic clear_bufs();
        rdy = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt[i] = 0; budget[i] = 0; word[i] = '0;
        end
        drive();
    endtask

    task automatic set_ready(input int ch, input logic [7:0] w, input int b);
        rdy[ch] = 1'b1; word[ch] = w; budget[ch] = b; cnt[ch] = 0;
        drive();
    endtask

    task automatic push(input logic [1:0] ch, input logic [7:0] d);
        exp_t e;
        e.ch = ch; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_bufs();
        exp_q.delete();
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (n < bound && !(exp_q.size() == 0 && !bus.out_valid && !busy)) begin
            tick(); n++;
        end
        if (!(exp_q.size() == 0 && !bus.out_valid && !busy)) tmo_count++;
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        while (n < bound && !bus.out_valid) begin tick(); n++; end
        if (!bus.out_valid) tmo_count++;
    endtask

    task automatic wait_pulse(input int bound);
        int n = 0;
        while (n < bound && bus.ch_data_processed == '0) begin tick(); n++; end
        if (bus.ch_data_processed == '0) tmo_count++;
    endtask

    task automatic wait_last_send(input int bound);
        int n = 0;
        while (n < bound && !(exp_q.size() == 1 && bus.out_valid)) begin tick(); n++; end
        if (!(exp_q.size() == 1 && bus.out_valid)) tmo_count++;
    endtask

    initial begin
        bus.out_ready = 1'b1;
        clear_bufs();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // 1: single word from channel 0
        push(2'd0, 8'hA5);
        set_ready(0, 8'hA5, 0);
        wait_drain(20);
        idle_chk = 1'b1; repeat (3) tick(); idle_chk = 1'b0;

        // 2: all channels ready, one word every 3 cycles, order 0,1,2,3,0
        do_reset();
        chk_gap = 1'b1;
        push(2'd0, 8'h10); push(2'd1, 8'h11); push(2'd2, 8'h12);
        push(2'd3, 8'h13); push(2'd0, 8'h10);
        set_ready(0, 8'h10, 1); set_ready(1, 8'h11, 0);
        set_ready(2, 8'h12, 0); set_ready(3, 8'h13, 0);
        wait_drain(60);
        chk_gap = 1'b0;

        // 3: downstream stall for 5 cycles with another requester waiting
        do_reset();
        bus.out_ready = 1'b0;
        push(2'd2, 8'h5C);
        set_ready(2, 8'h5C, 0);
        wait_valid(10);
        push(2'd1, 8'h3B);
        set_ready(1, 8'h3B, 0);
        repeat (5) tick();
        bus.out_ready = 1'b1;
        wait_drain(30);

        // 4: mask 1010 alternates 1,3; enable drop in SEND finishes the word only
        do_reset();
        ch_mask = 4'b1010;
        push(2'd1, 8'h21); push(2'd3, 8'h23); push(2'd1, 8'h21); push(2'd3, 8'h23);
        set_ready(0, 8'h20, 0); set_ready(1, 8'h21, 2);
        set_ready(2, 8'h22, 0); set_ready(3, 8'h23, 1);
        wait_last_send(60);
        enable = 1'b0;
        wait_drain(20);
        idle_chk = 1'b1; repeat (4) tick(); idle_chk = 1'b0;
        enable  = 1'b1;
        ch_mask = 4'hF;

        // 5: async reset during ACK, channel 0 wins first afterwards
        do_reset();
        push(2'd3, 8'h77);
        set_ready(3, 8'h77, 0);
        wait_pulse(10);
        #2 reset_n = 1'b0;
        exp_q.delete();
        clear_bufs();
        tick(); tick();
        reset_n = 1'b1;
        tick();
        push(2'd0, 8'h01); push(2'd3, 8'h77);
        set_ready(0, 8'h01, 0); set_ready(3, 8'h77, 0);
        wait_drain(30);

        // 6: channels 0 and 2 repeatedly ready
        do_reset();
`ifdef SENSOR_ARB_PRIO0_EN
        push(2'd0, 8'hC0); push(2'd0, 8'hC0); push(2'd2, 8'hC2); push(2'd2, 8'hC2);
`else
        push(2'd0, 8'hC0); push(2'd2, 8'hC2); push(2'd0, 8'hC0); push(2'd2, 8'hC2);
`endif
        set_ready(0, 8'hC0, 1); set_ready(2, 8'hC2, 1);
        wait_drain(60);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- monitor / scoreboard (sole owner of the counters) ----
    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    logic       prev_valid, prev_ready;
    logic [7:0] prev_data;
    logic [1:0] prev_ch;
    logic [3:0] prev_pulse;
    bit         have_prev = 1'b0;
    int         cyc       = 0;
    int         last_hs   = -1;
    int         tmo_seen  = 0;

    initial begin
        exp_t       e;
        logic [3:0] pulse;
        logic [3:0] want;
        forever begin
            @(negedge clk or negedge reset_n);
            #1;
            pulse = bus.ch_data_processed;
            if (!reset_n) begin
                chk(!bus.out_valid && pulse == '0 && bus.out_data == '0 && bus.out_ch == '0 && !busy,
                    "reset_state", {bus.out_valid, busy, pulse, bus.out_ch, bus.out_data}, 32'h0);
                have_prev = 1'b0;
                last_hs   = -1;
                continue;
            end
            cyc++;
            if (tmo_seen != tmo_count) begin
                chk(1'b0, "timeout", 32'(tmo_count), 32'(tmo_seen));
                tmo_seen = tmo_count;
            end
            if (have_prev && prev_pulse != '0)
                chk(bus.out_valid && pulse == '0, "ack_to_send", {bus.out_valid, pulse}, {1'b1, 4'h0});
            if (have_prev && prev_valid && !prev_ready)
                chk(bus.out_valid && bus.out_data == prev_data && bus.out_ch == prev_ch && pulse == '0,
                    "send_hold", {bus.out_valid, pulse, bus.out_ch, bus.out_data},
                    {1'b1, 4'h0, prev_ch, prev_data});
            if (pulse != '0) begin
                chk($onehot(pulse) && busy && !bus.out_valid, "pulse_shape",
                    {busy, bus.out_valid, pulse}, {1'b1, 1'b0, 4'h0});
                if (exp_q.size() == 0) begin
                    chk(1'b0, "pulse_unexpected", {28'h0, pulse}, 32'h0);
                end else begin
                    want = 4'b0001 << exp_q[0].ch;
                    chk(pulse == want, "pulse_ch", {28'h0, pulse}, {28'h0, want});
                end
            end
            if (idle_chk)
                chk(!busy && !bus.out_valid && pulse == '0, "idle", {busy, bus.out_valid, pulse}, 32'h0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "word_unexpected", {bus.out_ch, bus.out_data}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk(bus.out_ch == e.ch && bus.out_data == e.data, "word",
                        {bus.out_ch, bus.out_data}, {e.ch, e.data});
                end
                if (chk_gap && last_hs >= 0)
                    chk(cyc - last_hs == 3, "word_gap", 32'(cyc - last_hs), 32'd3);
                last_hs = cyc;
            end
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
            prev_data  = bus.out_data;
            prev_ch    = bus.out_ch;
            prev_pulse = pulse;
            have_prev  = 1'b1;
        end
    end

endmodule : tb_sensor_arbiter

`default_nettype wire
